dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Shares the single-port data memory between two requesters: port C (core load/store) and port D (debug/DMA).
// - The memory only supports aligned 64-bit doubleword accesses, so this block adds sub-doubleword (byte/half/word) loads and stores.
// - Loads are extracted from the doubleword with sign or zero extension. Sub-doubleword stores use read-modify-write.
// - Sits between the requesters and the data memory; it is the only driver of the memory ports.
// PARAMETERS
// - ADDR_W  64  requester address width (memory decodes bits [9:3] only)
// - DATA_W  64  data width; only 64 is supported
// PORTS
// - clk            in   1       clock; all logic on posedge clk
// - rst            in   1       reset; synchronous, active-high
// - c_req/d_req    in   1       request valid; held with fields stable until gnt
// - c_we/d_we      in   1       1 = store, 0 = load
// - c_size/d_size  in   2       00 byte, 01 half, 10 word, 11 double
// - c_uns/d_uns    in   1       load zero-extends when 1, sign-extends when 0
// - c_addr/d_addr  in   ADDR_W  byte address
// - c_wdata/d_wdata in  DATA_W  store data, right-justified
// - c_gnt/d_gnt    out  1       one-cycle pulse: request accepted, fields sampled
// - c_rvalid/d_rvalid out 1     one-cycle pulse: access complete
// - c_rdata/d_rdata out DATA_W  load result; valid only with rvalid; 0 for stores
// - c_err/d_err    out  1       misaligned access; valid only with rvalid
// - mem_address    out  ADDR_W  {addr[ADDR_W-1:3],3'b0}
// - mem_write_data out  DATA_W  doubleword to write
// - mem_write_en   out  1       memory write enable
// - mem_read_en    out  1       memory read enable
// - mem_read_data  in   DATA_W  memory read data; combinational, same cycle
// BEHAVIOUR
// - FSM states: IDLE, ACCESS, WRITE, RESP.
// - Reset: state=IDLE; last=D (so C wins the first tie).
// - Reset values: all gnt/rvalid/err=0; all rdata=0; mem_write_en=0; mem_read_en=0; mem_address=0; mem_write_data=0.
// - IDLE: if any req, grant one port: single request wins; on a tie, the port != last wins.
//   Pulse that port's gnt; latch we/size/uns/addr/wdata and owner; set last=owner; go to ACCESS.
// - ACCESS: drive mem_address from the latched address.
//   Misaligned (addr[0] for half, addr[1:0] for word, addr[2:0] for double nonzero): no memory enables, set err, go to RESP.
//   Load: mem_read_en=1; capture mem_read_data into rbuf; go to RESP.
//   Double store: mem_write_en=1, mem_write_data=wdata; go to RESP.
//   Sub-doubleword store: mem_read_en=1, capture rbuf, go to WRITE.
// - WRITE: mem_write_en=1. mem_write_data = rbuf with lanes addr[2:0]..addr[2:0]+bytes-1 replaced by the low bytes of wdata (little-endian). Go to RESP.
// - RESP: pulse owner rvalid. Owner rdata = (rbuf >> 8*addr[2:0]) truncated to size, then sign- or zero-extended; 0 for stores or err. Go to IDLE.
// - Latency from the gnt cycle T: load and double store rvalid at T+2; sub-doubleword store rvalid at T+3; misaligned rvalid at T+2.
// - Issue rate: one access in flight; no gnt while not in IDLE. Requests arriving during a busy cycle wait.
// - Handshake: a requester may drop req before gnt (the request is withdrawn). After gnt it must not reassert req before its own rvalid.
// - Non-owner outputs stay 0 throughout.
// - rst asserted in any state: next edge enters IDLE; no write is issued on that edge; the in-flight access is dropped with no rvalid. Memory contents are untouched.
// - Memory enables are never high outside ACCESS/WRITE; mem_write_en and the owner's rvalid are never high in the same cycle.
// CONFIGURATION
// - DMEM_ARB_FIXED_PRIORITY_EN defined: on a tie port C always wins; port D can starve; last is unused.
// - Macro undefined (default): round-robin tie-break as above.
// TESTING
// - Preload word 0x10 = 0x1122334455667788; C loads double @0x10 -> c_gnt at T, c_rvalid at T+2, c_rdata=0x1122334455667788.
// - C stores byte 0xAB @0x13 -> c_rvalid at T+3; mem[0x10] = 0x11223344AB667788.
//   Then C loads byte signed @0x13 -> 0xFFFFFFFFFFFFFFAB; unsigned -> 0x00000000000000AB.
// - C and D both request from reset and are held continuously -> grant order C,D,C,D; no overlap; each gets its correct rvalid.
// - D loads half @0x11 -> d_err=1 with d_rvalid at T+2, d_rdata=0; mem_write_en and mem_read_en stay 0.
// - C sub-word store with rst asserted in WRITE -> no mem_write_en; memory unchanged; IDLE next cycle; no c_rvalid.
// - With DMEM_ARB_FIXED_PRIORITY_EN, C and D requesting continuously -> only C is granted. Drop c_req -> D granted next IDLE.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for dmem_arbiter: request fields flow from the
// requester (master) to the arbiter (slave); grant/response flow back.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, size, uns, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, uns, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core (port c) and debug/DMA (port d).
// Adds byte/half/word loads (sign/zero extended) and read-modify-write
// sub-doubleword stores on top of an aligned 64-bit single-port memory.
// Build option: define DMEM_ARB_FIXED_PRIORITY_EN to make port c always win
// a tie (port d may starve); otherwise ties alternate round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     c,
  dmem_arbiter_if.slave     d,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;
  typedef enum logic {OWN_C, OWN_D} owner_e;

  state_e state, state_n;
  owner_e owner, pick;
  logic   grant;

  logic              sel_we, sel_uns;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              r_we, r_uns, r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, rbuf;

  logic              misaligned;
  logic [5:0]        shamt;
  logic [DATA_W-1:0] lane_mask, merged, shifted, load_val;
  logic              resp;

`ifndef DMEM_ARB_FIXED_PRIORITY_EN
  owner_e last;
`endif

  // Arbitration: pick a requester and mux its fields for latching
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    pick = c.req ? OWN_C : OWN_D;
`else
    if (c.req && d.req) pick = (last == OWN_C) ? OWN_D : OWN_C;
    else                pick = c.req ? OWN_C : OWN_D;
`endif
    grant     = (state == IDLE) && (c.req || d.req) && !rst;
    sel_we    = (pick == OWN_C) ? c.we    : d.we;
    sel_uns   = (pick == OWN_C) ? c.uns   : d.uns;
    sel_size  = (pick == OWN_C) ? c.size  : d.size;
    sel_addr  = (pick == OWN_C) ? c.addr  : d.addr;
    sel_wdata = (pick == OWN_C) ? c.wdata : d.wdata;
  end

  // Alignment check, store lane merge and load extraction
  always_comb begin
    shamt = {r_addr[2:0], 3'b000};
    case (r_size)
      2'b00: begin
        misaligned = 1'b0;
        lane_mask  = {{(DATA_W-8){1'b0}}, 8'hFF};
      end
      2'b01: begin
        misaligned = r_addr[0];
        lane_mask  = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      end
      2'b10: begin
        misaligned = |r_addr[1:0];
        lane_mask  = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      end
      default: begin
        misaligned = |r_addr[2:0];
        lane_mask  = '1;
      end
    endcase
    merged  = (rbuf & ~(lane_mask << shamt)) | ((r_wdata & lane_mask) << shamt);
    shifted = rbuf >> shamt;
    case (r_size)
      2'b00:   load_val = {{(DATA_W-8){shifted[7] & ~r_uns}}, shifted[7:0]};
      2'b01:   load_val = {{(DATA_W-16){shifted[15] & ~r_uns}}, shifted[15:0]};
      2'b10:   load_val = {{(DATA_W-32){shifted[31] & ~r_uns}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (c.req || d.req) state_n = ACCESS;
      ACCESS: begin
        if (misaligned || !r_we || (r_size == 2'b11)) state_n = RESP;
        else                                          state_n = WRITE;
      end
      WRITE:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Memory port drive; suppressed under reset so no write lands on the reset edge
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    mem_read_en    = 1'b0;
    if (!rst) begin
      case (state)
        ACCESS: begin
          mem_address = {r_addr[ADDR_W-1:3], 3'b000};
          if (!misaligned) begin
            if (r_we && (r_size == 2'b11)) begin
              mem_write_en   = 1'b1;
              mem_write_data = r_wdata;
            end else begin
              mem_read_en = 1'b1;
            end
          end
        end
        WRITE: begin
          mem_address    = {r_addr[ADDR_W-1:3], 3'b000};
          mem_write_en   = 1'b1;
          mem_write_data = merged;
        end
        default: ;
      endcase
    end
  end

  // Requester-side grant and response outputs; only the owner sees a response
  always_comb begin
    resp     = (state == RESP) && !rst;
    c.gnt    = grant && (pick == OWN_C);
    d.gnt    = grant && (pick == OWN_D);
    c.rvalid = resp && (owner == OWN_C);
    d.rvalid = resp && (owner == OWN_D);
    c.err    = resp && (owner == OWN_C) && r_err;
    d.err    = resp && (owner == OWN_D) && r_err;
    c.rdata  = (resp && (owner == OWN_C) && !r_we && !r_err) ? load_val : '0;
    d.rdata  = (resp && (owner == OWN_D) && !r_we && !r_err) ? load_val : '0;
  end

  // State register, request latch and read buffer capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_C;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
      last    <= OWN_D;
`endif
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      rbuf    <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        owner   <= pick;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
        last    <= pick;
`endif
        r_we    <= sel_we;
        r_uns   <= sel_uns;
        r_size  <= sel_size;
        r_addr  <= sel_addr;
        r_wdata <= sel_wdata;
      end
      if (state == ACCESS) begin
        r_err <= misaligned;
        if (mem_read_en) rbuf <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 128 x 64-bit memory.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;

  logic        pre_we;
  logic [6:0]  pre_idx;
  logic [63:0] pre_data;
  logic [63:0] mem [0:127];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) cif ();
  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) dif ();

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .c              (cif),
    .d              (dif),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[9:3]];

  always @(posedge clk) begin
    if (pre_we)            mem[pre_idx] <= pre_data;
    else if (mem_write_en) mem[mem_address[9:3]] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit use_d, input bit req, input bit we, input logic [1:0] size,
                       input bit uns, input logic [63:0] addr, input logic [63:0] wdata);
    if (use_d) begin
      dif.req = req; dif.we = we; dif.size = size; dif.uns = uns; dif.addr = addr; dif.wdata = wdata;
    end else begin
      cif.req = req; cif.we = we; cif.size = size; cif.uns = uns; cif.addr = addr; cif.wdata = wdata;
    end
  endtask

  // Issue one request from IDLE and follow it to rvalid (bounded); lat counts cycles after gnt.
  task automatic xact(input bit use_d, input bit we, input logic [1:0] size, input bit uns,
                      input logic [63:0] addr, input logic [63:0] wdata,
                      output int lat, output logic [63:0] rdata, output logic err,
                      output bit wr_seen, output bit rd_seen);
    bit got = 0;
    lat = -1; rdata = '0; err = 1'b0; wr_seen = 0; rd_seen = 0;
    drive(use_d, 1'b1, we, size, uns, addr, wdata);
    #1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (use_d ? dif.gnt : cif.gnt) got = 1;
      else begin @(negedge clk); #1; end
    end
    @(negedge clk);
    drive(use_d, 1'b0, we, size, uns, addr, wdata);
    #1;
    if (got) begin
      for (int n = 1; n <= 6; n++) begin
        wr_seen |= mem_write_en;
        rd_seen |= mem_read_en;
        if (use_d ? dif.rvalid : cif.rvalid) begin
          lat   = n;
          rdata = use_d ? dif.rdata : cif.rdata;
          err   = use_d ? dif.err : cif.err;
          break;
        end
        @(negedge clk); #1;
      end
    end
    @(negedge clk); #1;
  endtask

  int          lat;
  logic [63:0] rd;
  logic        er;
  bit          ws, rs;
  int          order[$];
  int          rvq[$];
  int          overlap;

  initial begin
    rst = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0);

    // Preload memory during reset
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 7'd2; pre_data = 64'h1122334455667788;
    @(negedge clk);
    pre_idx = 7'd3; pre_data = 64'h0;
    @(negedge clk);
    pre_we = 1'b0;
    #1;
    chk("rst_c_gnt", 64'(cif.gnt), 64'd0);
    chk("rst_d_gnt", 64'(dif.gnt), 64'd0);
    chk("rst_c_rvalid", 64'(cif.rvalid), 64'd0);
    chk("rst_d_rvalid", 64'(dif.rvalid), 64'd0);
    chk("rst_c_err", 64'(cif.err), 64'd0);
    chk("rst_d_err", 64'(dif.err), 64'd0);
    chk("rst_c_rdata", cif.rdata, 64'd0);
    chk("rst_d_rdata", dif.rdata, 64'd0);
    chk("rst_mem_we", 64'(mem_write_en), 64'd0);
    chk("rst_mem_re", 64'(mem_read_en), 64'd0);
    chk("rst_mem_addr", mem_address, 64'd0);
    chk("rst_mem_wdata", mem_write_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // C double load @0x10, stepped cycle by cycle
    drive(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
    #1;
    chk("ld_c_gnt_T", 64'(cif.gnt), 64'd1);
    chk("ld_d_gnt_T", 64'(dif.gnt), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
    #1;
    chk("ld_access_re", 64'(mem_read_en), 64'd1);
    chk("ld_access_we", 64'(mem_write_en), 64'd0);
    chk("ld_access_addr", mem_address, 64'h10);
    chk("ld_access_gnt", 64'(cif.gnt), 64'd0);
    chk("ld_rvalid_T1", 64'(cif.rvalid), 64'd0);
    @(negedge clk); #1;
    chk("ld_rvalid_T2", 64'(cif.rvalid), 64'd1);
    chk("ld_rdata", cif.rdata, 64'h1122334455667788);
    chk("ld_d_rvalid", 64'(dif.rvalid), 64'd0);
    chk("ld_d_rdata", dif.rdata, 64'd0);
    chk("ld_resp_re", 64'(mem_read_en), 64'd0);
    @(negedge clk); #1;
    chk("ld_rvalid_T3", 64'(cif.rvalid), 64'd0);

    // C byte store 0xAB @0x13 (read-modify-write)
    xact(1'b0, 1'b1, 2'b00, 1'b0, 64'h13, 64'h00000000000000AB, lat, rd, er, ws, rs);
    chk("sb_lat", 64'(lat), 64'd3);
    chk("sb_rdata", rd, 64'd0);
    chk("sb_wr", 64'(ws), 64'd1);
    chk("sb_mem", mem[2], 64'h11223344AB667788);

    xact(1'b0, 1'b0, 2'b00, 1'b0, 64'h13, 64'h0, lat, rd, er, ws, rs);
    chk("lbs_lat", 64'(lat), 64'd2);
    chk("lbs_rdata", rd, 64'hFFFFFFFFFFFFFFAB);
    xact(1'b0, 1'b0, 2'b00, 1'b1, 64'h13, 64'h0, lat, rd, er, ws, rs);
    chk("lbu_rdata", rd, 64'h00000000000000AB);
    xact(1'b1, 1'b0, 2'b01, 1'b1, 64'h12, 64'h0, lat, rd, er, ws, rs);
    chk("lhu_rdata", rd, 64'h000000000000AB66);
    xact(1'b1, 1'b0, 2'b01, 1'b0, 64'h12, 64'h0, lat, rd, er, ws, rs);
    chk("lhs_rdata", rd, 64'hFFFFFFFFFFFFAB66);

    // Both requesting continuously from reset
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    overlap = 0;
    for (int i = 0; i < 12; i++) begin
      if (cif.gnt) order.push_back(0);
      if (dif.gnt) order.push_back(1);
      if (cif.gnt && dif.gnt) overlap++;
      if (cif.rvalid) begin
        rvq.push_back(0);
        chk("rr_c_rdata", cif.rdata, 64'h11223344AB667788);
      end
      if (dif.rvalid) begin
        rvq.push_back(1);
        chk("rr_d_rdata", dif.rdata, 64'h11223344AB667788);
      end
      @(negedge clk); #1;
    end
    chk("rr_overlap", 64'(overlap), 64'd0);
    chk("rr_ngnt", 64'(order.size()), 64'd4);
    chk("rr_nrvalid", 64'(rvq.size()), 64'd4);
    for (int i = 0; i < 4 && i < order.size() && i < rvq.size(); i++) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
      chk("fp_gnt_order", 64'(order[i]), 64'd0);
`else
      chk("rr_gnt_order", 64'(order[i]), 64'(i % 2));
`endif
      chk("rr_rvalid_owner", 64'(rvq[i]), 64'(order[i]));
    end
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    cif.req = 1'b0;
    #1;
    chk("fp_d_after_drop", 64'(dif.gnt), 64'd1);
    @(negedge clk);
    dif.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
`else
    cif.req = 1'b0;
    dif.req = 1'b0;
`endif
    @(negedge clk);

    // D misaligned half @0x11
    xact(1'b1, 1'b0, 2'b01, 1'b0, 64'h11, 64'h0, lat, rd, er, ws, rs);
    chk("mis_lat", 64'(lat), 64'd2);
    chk("mis_err", 64'(er), 64'd1);
    chk("mis_rdata", rd, 64'd0);
    chk("mis_wr", 64'(ws), 64'd0);
    chk("mis_rd", 64'(rs), 64'd0);

    // Word store: only the low four bytes of wdata land
    xact(1'b0, 1'b1, 2'b10, 1'b0, 64'h14, 64'hFFFF0000DEADBEEF, lat, rd, er, ws, rs);
    chk("sw_lat", 64'(lat), 64'd3);
    chk("sw_mem", mem[2], 64'hDEADBEEFAB667788);
    xact(1'b0, 1'b0, 2'b10, 1'b0, 64'h14, 64'h0, lat, rd, er, ws, rs);
    chk("lws_rdata", rd, 64'hFFFFFFFFDEADBEEF);
    xact(1'b1, 1'b0, 2'b10, 1'b1, 64'h14, 64'h0, lat, rd, er, ws, rs);
    chk("lwu_rdata", rd, 64'h00000000DEADBEEF);

    // Double store and readback
    xact(1'b1, 1'b1, 2'b11, 1'b0, 64'h18, 64'h0123456789ABCDEF, lat, rd, er, ws, rs);
    chk("sd_lat", 64'(lat), 64'd2);
    chk("sd_err", 64'(er), 64'd0);
    chk("sd_mem", mem[3], 64'h0123456789ABCDEF);
    xact(1'b0, 1'b0, 2'b00, 1'b0, 64'h18, 64'h0, lat, rd, er, ws, rs);
    chk("lb_ef", rd, 64'hFFFFFFFFFFFFFFEF);
    xact(1'b0, 1'b0, 2'b01, 1'b0, 64'h1E, 64'h0, lat, rd, er, ws, rs);
    chk("lh_top", rd, 64'h0000000000000123);
    xact(1'b0, 1'b0, 2'b11, 1'b0, 64'h1C, 64'h0, lat, rd, er, ws, rs);
    chk("mis_dbl_err", 64'(er), 64'd1);

    // Reset during WRITE of a sub-word store
    drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 64'h10, 64'h00000000000000CD);
    #1;
    chk("rw_gnt", 64'(cif.gnt), 64'd1);
    @(negedge clk);
    cif.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_no_we", 64'(mem_write_en), 64'd0);
    chk("rw_no_rvalid0", 64'(cif.rvalid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
    #1;
    chk("rw_no_rvalid1", 64'(cif.rvalid), 64'd0);
    chk("rw_idle_gnt", 64'(dif.gnt), 64'd1);
    chk("rw_mem_kept", mem[2], 64'hDEADBEEFAB667788);
    @(negedge clk);
    dif.req = 1'b0;
    #1;
    chk("rw_no_rvalid2", 64'(cif.rvalid), 64'd0);
    @(negedge clk); #1;
    chk("rw_d_rvalid", 64'(dif.rvalid), 64'd1);
    chk("rw_d_rdata", dif.rdata, 64'hDEADBEEFAB667788);
    chk("rw_c_quiet", 64'(cif.rvalid), 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
